// File: rtl/alu_pkg.sv
// Shared constants for the ALU command stage: operand width, ALU opcodes
// and the stage FSM state encoding.
package alu_pkg;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_SHR = 3'b101;
    localparam logic [2:0] OP_CUT = 3'b110;
    localparam logic [2:0] OP_ADD = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu_cmd_stage.sv
// Registered command/response wrapper in front of the combinational 32-bit ALU.
// Define ALU_CMD_CARRY_CHAIN_EN to keep a carry flag for chained multi-word ADDs.
module alu_cmd_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_opcode,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic             cmd_cin,
    input  logic             cmd_use_carry,
    output logic [2:0]       alu_opcode,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_cin,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_zero,
    output logic             carry_flag
);
    import alu_pkg::*;

    state_t state;
    logic   cin_sel;
    logic   accept;
    logic   exec_add;

    assign accept    = (state == IDLE) && cmd_valid;
    assign exec_add  = (state == EXEC) && (alu_opcode == OP_ADD);
    assign cmd_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

`ifdef ALU_CMD_CARRY_CHAIN_EN
    logic carry_q;

    assign cin_sel    = cmd_use_carry ? carry_q : cmd_cin;
    assign carry_flag = carry_q;

    // Flag moves only on the EXEC->RESP edge of an ADD, ready for the next chained ADD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            carry_q <= 1'b0;
        else if (exec_add)
            carry_q <= alu_cout;
    end
`else
    logic unused_use_carry;

    assign unused_use_carry = cmd_use_carry;
    assign cin_sel          = cmd_cin;
    assign carry_flag       = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            unique case (state)
                IDLE:    if (cmd_valid) state <= EXEC;
                EXEC:    state <= RESP;
                RESP:    if (rsp_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Operand registers load only on accept so the ALU inputs stay quiet otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_opcode <= OP_NOT;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cin    <= 1'b0;
        end else if (accept) begin
            alu_opcode <= cmd_opcode;
            alu_a      <= cmd_a;
            alu_b      <= cmd_b;
            alu_cin    <= cin_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result <= '0;
            rsp_cout   <= 1'b0;
            rsp_zero   <= 1'b0;
        end else if (state == EXEC) begin
            rsp_result <= alu_result;
            rsp_cout   <= exec_add & alu_cout;
            rsp_zero   <= (alu_result == '0);
        end
    end

endmodule

// File: tb/tb_alu_cmd_stage.sv
// Randomized self-checking bench for alu_cmd_stage with a behavioural ALU beside it.
// Honors ALU_CMD_CARRY_CHAIN_EN when building the expected carry behaviour.
module tb_alu_cmd_stage;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode = 3'd0;
    logic [31:0] cmd_a = 32'd0;
    logic [31:0] cmd_b = 32'd0;
    logic        cmd_cin = 1'b0;
    logic        cmd_use_carry = 1'b0;
    logic [2:0]  alu_opcode;
    logic [31:0] alu_a, alu_b;
    logic        alu_cin;
    logic [31:0] alu_result;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_cout, rsp_zero, carry_flag;

    int n_vec = 0;
    int n_err = 0;
    logic m_carry = 1'b0;

`ifdef ALU_CMD_CARRY_CHAIN_EN
    localparam bit CHAIN = 1'b1;
`else
    localparam bit CHAIN = 1'b0;
`endif

    always #5 clk = ~clk;

    alu_cmd_stage #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_use_carry(cmd_use_carry),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_zero(rsp_zero), .carry_flag(carry_flag)
    );

    // {cout, result} of the ALU for one operation
    function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic cin);
        logic [32:0] s;
        int n;
        n = int'(b & 32'h3f);
        case (op)
            OP_NOT:  return {1'b0, ~a};
            OP_AND:  return {1'b0, a & b};
            OP_OR:   return {1'b0, a | b};
            OP_XOR:  return {1'b0, a ^ b};
            OP_SHL:  return (n >= 32) ? 33'd0 : {1'b0, a << n};
            OP_SHR:  return (n >= 32) ? 33'd0 : {1'b0, a >> n};
            OP_CUT:  return (n >= 32) ? {1'b0, a} : {1'b0, a & ((32'd1 << n) - 32'd1)};
            default: begin
                s = {1'b0, a} + {1'b0, b} + {32'd0, cin};
                return s;
            end
        endcase
    endfunction

    // Environment ALU; drives junk carry on non-ADD ops so the stage's forcing is exercised.
    logic [32:0] alu_tmp;
    always_comb begin
        alu_tmp    = alu_ref(alu_opcode, alu_a, alu_b, alu_cin);
        alu_result = alu_tmp[31:0];
        alu_cout   = (alu_opcode == OP_ADD) ? alu_tmp[32] : alu_a[0];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".rsp"}, {31'd0, rsp_cout, rsp_zero, rsp_result}, 64'd0);
        chk({tag, ".alu"}, {alu_opcode, alu_cin, alu_a}, 64'd0);
        chk({tag, ".alu_b"}, 64'(alu_b), 64'd0);
        chk({tag, ".carry"}, 64'(carry_flag), 64'd0);
    endtask

    // Full transaction: accept, one EXEC cycle, response held for 'stall' cycles.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic cin, input logic uc, input int stall);
        logic [32:0] e;
        logic        eff_cin;
        logic        e_cout;
        int          t;
        eff_cin = (CHAIN && uc) ? m_carry : cin;
        e       = alu_ref(op, a, b, eff_cin);
        e_cout  = (op == OP_ADD) ? e[32] : 1'b0;
        if (CHAIN && op == OP_ADD) m_carry = e[32];

        cmd_valid = 1'b1; cmd_opcode = op; cmd_a = a; cmd_b = b;
        cmd_cin = cin; cmd_use_carry = uc; rsp_ready = 1'b0;
        t = 0;
        while (!cmd_ready && t < 20) begin tick(); t++; end
        if (t == 20) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_a = $urandom; cmd_b = $urandom;
        chk("exec.valid_ready", {62'd0, rsp_valid, cmd_ready}, 64'd0);
        chk("exec.alu_ops", {alu_opcode, alu_a}, {op, a});
        chk("exec.alu_b_cin", {alu_cin, alu_b}, {eff_cin, b});
        tick();
        for (int s = 0; s <= stall; s++) begin
            chk("rsp.valid_ready", {62'd0, rsp_valid, cmd_ready}, 64'd2);
            chk("rsp.result", 64'(rsp_result), 64'(e[31:0]));
            chk("rsp.cout_zero", {62'd0, rsp_cout, rsp_zero}, {62'd0, e_cout, e[31:0] == 32'd0});
            chk("rsp.carry_flag", 64'(carry_flag), 64'(m_carry));
            if (s < stall) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("idle.valid_ready", {62'd0, rsp_valid, cmd_ready}, 64'd1);
        chk("idle.alu_hold", {alu_opcode, alu_a}, {op, a});
    endtask

    initial begin
        logic [31:0] ba [4];
        logic [31:0] bb [4];
        int          idx, got;
        logic        acc;

        repeat (2) tick();
        chk_reset_vals("reset");
        rst_n = 1'b1;
        tick();
        chk_reset_vals("post_reset");

        issue(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 0);
        issue(OP_SHL, 32'h0000_0001, 32'h0000_0004, 1'b0, 1'b1, 0);
        issue(OP_ADD, 32'h0, 32'h0, 1'b0, 1'b1, 1);
        issue(OP_CUT, 32'hDEAD_BEEF, 32'd8, 1'b0, 1'b0, 5);
        issue(OP_SHR, 32'h8000_0000, 32'd40, 1'b1, 1'b0, 0);

        // reset asserted mid-EXEC of an XOR drops the command
        cmd_valid = 1'b1; cmd_opcode = OP_XOR; cmd_a = 32'hFF; cmd_b = 32'h0F;
        tick();
        cmd_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 m_carry = 1'b0;
        chk_reset_vals("mid_exec_reset");
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("after_reset.valid_ready", {62'd0, rsp_valid, cmd_ready}, 64'd1);
        end

        // back-to-back ANDs with both handshakes held high
        for (int i = 0; i < 4; i++) begin ba[i] = $urandom; bb[i] = $urandom; end
        idx = 0; got = 0;
        cmd_opcode = OP_AND; cmd_a = ba[0]; cmd_b = bb[0]; cmd_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            acc = cmd_ready & cmd_valid;
            tick();
            if (acc) begin
                idx++;
                if (idx < 4) begin cmd_a = ba[idx]; cmd_b = bb[idx]; end
                else cmd_valid = 1'b0;
            end
            if (rsp_valid) begin
                if (got < 4) chk("b2b.result", 64'(rsp_result), 64'(ba[got] & bb[got]));
                got++;
            end
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        chk("b2b.count", {32'(idx), 32'(got)}, {32'd4, 32'd4});
        chk("b2b.idle", {62'd0, rsp_valid, cmd_ready}, 64'd1);

        // randomized traffic, ADDs biased for carry chains
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = ($urandom_range(0, 2) == 0) ? OP_ADD : 3'($urandom_range(0, 7));
            a  = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            b  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : $urandom;
            issue(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
